// File: rtl/pkt_rr_merge.sv
// Round-robin merge of N_CH packet channels; whole packets are buffered per channel and only committed
// packets are forwarded. First word 2 cycles after tail commit; inputs have no backpressure, overflow drops.
module pkt_rr_merge #(
  parameter int N_CH = 2,
  parameter int AW   = 6,
  parameter int CH_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      data_in_valid,
  input  logic [N_CH*134-1:0]  data_in,
  output logic                 data_out_valid,
  output logic [133:0]         data_out,
  output logic [CH_W-1:0]      data_out_ch,
  output logic [N_CH-1:0]      drop_pulse
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef struct packed {
    logic [1:0]   tag;
    logic [3:0]   vld_nib;
    logic [127:0] dat;
  } word_t;

  typedef enum logic [1:0] {W_IDLE, W_OPEN, W_DROP} wr_state_t;
  typedef enum logic {A_ARB, A_SEND} arb_state_t;

  word_t       mem [N_CH][DEPTH];
  word_t       in_word [N_CH];

  logic [AW:0] wr_ptr [N_CH];
  logic [AW:0] commit_ptr [N_CH];
  logic [AW:0] rd_ptr [N_CH];
  logic [AW:0] wr_ptr_nxt [N_CH];
  logic [AW:0] commit_nxt [N_CH];
  logic [AW-1:0] waddr [N_CH];
  wr_state_t   ws [N_CH];
  wr_state_t   ws_nxt [N_CH];
  logic [N_CH-1:0] we;
  logic [N_CH-1:0] drop_nxt;
  logic [N_CH-1:0] ready;
  logic [N_CH-1:0] rd_inc;

  arb_state_t  arb, arb_nxt;
  logic [CH_W-1:0] gnt, gnt_nxt;
  logic [CH_W-1:0] last_grant, last_nxt;
  logic [CH_W-1:0] out_ch_nxt;
  logic        out_vld_nxt;
  word_t       out_nxt;
  word_t       rd_word;

  // Write side: one FSM per channel, pointers roll back to commit_ptr on any discard.
  always_comb begin
    logic is_head;
    logic is_tail;
    logic rollback;
    logic full;
    logic [AW:0] base;
    wr_state_t st;
    is_head  = 1'b0;
    is_tail  = 1'b0;
    rollback = 1'b0;
    full     = 1'b0;
    base     = '0;
    st       = W_IDLE;
    we       = '0;
    drop_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_word[i]    = data_in[i*134 +: 134];
      wr_ptr_nxt[i] = wr_ptr[i];
      commit_nxt[i] = commit_ptr[i];
      ws_nxt[i]     = ws[i];
      waddr[i]      = '0;
      if (data_in_valid[i]) begin
        is_head  = in_word[i].tag[0];
        is_tail  = in_word[i].tag[1];
        rollback = (ws[i] == W_OPEN) && is_head;
        base     = rollback ? commit_ptr[i] : wr_ptr[i];
        full     = ((base - rd_ptr[i]) == FULL_OCC);
        st       = rollback ? W_IDLE : ws[i];
        drop_nxt[i]   = rollback;
        wr_ptr_nxt[i] = base;
        // A word belongs to a packet if one is open or it starts a new one.
        if (st == W_OPEN || is_head) begin
          if (full) begin
            drop_nxt[i]   = 1'b1;
            wr_ptr_nxt[i] = commit_ptr[i];
            ws_nxt[i]     = is_tail ? W_IDLE : W_DROP;
          end else begin
            we[i]         = 1'b1;
            waddr[i]      = base[AW-1:0];
            wr_ptr_nxt[i] = base + PTR_ONE;
            if (is_tail) begin
              commit_nxt[i] = base + PTR_ONE;
              ws_nxt[i]     = W_IDLE;
            end else begin
              ws_nxt[i]     = W_OPEN;
            end
          end
        end else if (st == W_DROP && is_tail) begin
          ws_nxt[i] = W_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (we[i]) mem[i][waddr[i]] <= in_word[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) ready[i] = (rd_ptr[i] != commit_ptr[i]);
  end

  assign rd_word = mem[gnt][rd_ptr[gnt][AW-1:0]];

  // Output arbiter: committed packets only, so a granted packet always streams gap-free.
  always_comb begin
    logic found;
    int cand;
    logic [CH_W-1:0] cand_ch;
    found       = 1'b0;
    cand        = 0;
    cand_ch     = '0;
    arb_nxt     = arb;
    gnt_nxt     = gnt;
    last_nxt    = last_grant;
    out_vld_nxt = 1'b0;
    out_nxt     = '0;
    out_ch_nxt  = data_out_ch;
    rd_inc      = '0;
    case (arb)
      A_ARB: begin
        for (int k = 1; k <= N_CH; k++) begin
          cand    = (int'(last_grant) + k) % N_CH;
          cand_ch = CH_W'(cand);
          if (!found && ready[cand_ch]) begin
            found    = 1'b1;
            gnt_nxt  = cand_ch;
            last_nxt = cand_ch;
            arb_nxt  = A_SEND;
          end
        end
      end
      A_SEND: begin
        out_vld_nxt  = 1'b1;
        out_nxt      = rd_word;
        out_ch_nxt   = gnt;
        rd_inc[gnt]  = 1'b1;
        if (rd_word.tag[1]) arb_nxt = A_ARB;
      end
      default: arb_nxt = A_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i]     <= '0;
        commit_ptr[i] <= '0;
        rd_ptr[i]     <= '0;
        ws[i]         <= W_IDLE;
      end
      arb            <= A_ARB;
      gnt            <= '0;
      last_grant     <= CH_W'(N_CH-1);
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_ch    <= '0;
      drop_pulse     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i]     <= wr_ptr_nxt[i];
        commit_ptr[i] <= commit_nxt[i];
        ws[i]         <= ws_nxt[i];
        if (rd_inc[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
      arb            <= arb_nxt;
      gnt            <= gnt_nxt;
      last_grant     <= last_nxt;
      data_out_valid <= out_vld_nxt;
      data_out       <= out_nxt;
      data_out_ch    <= out_ch_nxt;
      drop_pulse     <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_rr_merge.sv
// Directed bench for pkt_rr_merge with a 4-word buffer per channel.
module tb_pkt_rr_merge;
  localparam int N_CH = 2;
  localparam int AW   = 2;
  localparam int CH_W = 1;
  localparam int W    = 134;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   data_in_valid = '0;
  logic [N_CH*W-1:0] data_in = '0;
  logic              data_out_valid;
  logic [W-1:0]      data_out;
  logic [CH_W-1:0]   data_out_ch;
  logic [N_CH-1:0]   drop_pulse;

  pkt_rr_merge #(.N_CH(N_CH), .AW(AW), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .data_in(data_in),
    .data_out_valid(data_out_valid), .data_out(data_out), .data_out_ch(data_out_ch),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  int              log_cyc [$];
  logic [W-1:0]    log_dat [$];
  logic [CH_W-1:0] log_ch [$];
  int              drop_cnt [N_CH];
  int              drop_cyc [N_CH];

  always @(negedge clk) begin
    if (data_out_valid) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(data_out);
      log_ch.push_back(data_out_ch);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (drop_pulse[i]) begin
        drop_cnt[i]++;
        drop_cyc[i] = cyc;
      end
    end
  end

  function automatic logic [W-1:0] mk(input logic [1:0] tag, input logic [31:0] d);
    return {tag, 4'hF, 96'd0, d};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    log_cyc.delete();
    log_dat.delete();
    log_ch.delete();
    for (int i = 0; i < N_CH; i++) begin
      drop_cnt[i] = 0;
      drop_cyc[i] = -1;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [W-1:0] w0, input logic [W-1:0] w1);
    data_in_valid = v;
    data_in = {w1, w0};
    step();
    data_in_valid = '0;
    data_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++; if (data_out_valid !== 1'b0) $display("FAIL reset_vld: got %b want 0", data_out_valid); else passed++;
    total++; if (data_out !== '0) $display("FAIL reset_dat: got %h want 0", data_out); else passed++;
    total++; if (data_out_ch !== '0) $display("FAIL reset_ch: got %0d want 0", data_out_ch); else passed++;
    total++; if (drop_pulse !== '0) $display("FAIL reset_drop: got %b want 00", drop_pulse); else passed++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_d [3];
    logic [W-1:0] got;
    int t;
    int gc;
    exp_d[0] = mk(2'b01, 32'h1);
    exp_d[1] = mk(2'b00, 32'h2);
    exp_d[2] = mk(2'b10, 32'h3);
    clr();
    drive(2'b01, exp_d[0], '0);
    drive(2'b01, exp_d[1], '0);
    drive(2'b01, exp_d[2], '0);
    t = cyc;
    step(8);
    total++; if (log_dat.size() != 3) $display("FAIL basic_count: got %0d want 3", log_dat.size()); else passed++;
    for (int k = 0; k < 3; k++) begin
      got = (k < log_dat.size()) ? log_dat[k] : '1;
      gc  = (k < log_cyc.size()) ? log_cyc[k] : -1;
      total++; if (got !== exp_d[k]) $display("FAIL basic_dat[%0d]: got %h want %h", k, got, exp_d[k]); else passed++;
      total++; if (gc != t + 2 + k) $display("FAIL basic_cyc[%0d]: got %0d want %0d", k, gc, t + 2 + k); else passed++;
      total++; if (k < log_ch.size() && log_ch[k] !== 1'b0) $display("FAIL basic_ch[%0d]: got %0d want 0", k, log_ch[k]); else passed++;
    end
    total++; if (data_out_valid !== 1'b0 || data_out !== '0) $display("FAIL basic_idle: got vld %b dat %h want 0/0", data_out_valid, data_out); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] exp_d [4];
    logic         exp_c [4];
    int           exp_t [4];
    logic [W-1:0] got;
    int t;
    int gc;
    do_reset();
    clr();
    drive(2'b11, mk(2'b01, 32'h10), mk(2'b01, 32'h20));
    drive(2'b11, mk(2'b10, 32'h11), mk(2'b10, 32'h21));
    t = cyc;
    step(10);
    exp_d[0] = mk(2'b01, 32'h10); exp_c[0] = 1'b0; exp_t[0] = t + 2;
    exp_d[1] = mk(2'b10, 32'h11); exp_c[1] = 1'b0; exp_t[1] = t + 3;
    exp_d[2] = mk(2'b01, 32'h20); exp_c[2] = 1'b1; exp_t[2] = t + 5;
    exp_d[3] = mk(2'b10, 32'h21); exp_c[3] = 1'b1; exp_t[3] = t + 6;
    total++; if (log_dat.size() != 4) $display("FAIL same_count: got %0d want 4", log_dat.size()); else passed++;
    for (int k = 0; k < 4; k++) begin
      got = (k < log_dat.size()) ? log_dat[k] : '1;
      gc  = (k < log_cyc.size()) ? log_cyc[k] : -1;
      total++; if (got !== exp_d[k]) $display("FAIL same_dat[%0d]: got %h want %h", k, got, exp_d[k]); else passed++;
      total++; if (gc != exp_t[k]) $display("FAIL same_cyc[%0d]: got %0d want %0d", k, gc, exp_t[k]); else passed++;
      total++; if (k >= log_ch.size() || log_ch[k] !== exp_c[k]) $display("FAIL same_ch[%0d]: want %0d", k, exp_c[k]); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] got;
    int t5;
    int t;
    clr();
    drive(2'b01, mk(2'b01, 32'h40), '0);
    drive(2'b01, mk(2'b00, 32'h41), '0);
    drive(2'b01, mk(2'b00, 32'h42), '0);
    drive(2'b01, mk(2'b00, 32'h43), '0);
    drive(2'b01, mk(2'b10, 32'h44), '0);
    t5 = cyc;
    step(6);
    total++; if (drop_cnt[0] != 1) $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt[0]); else passed++;
    total++; if (drop_cyc[0] != t5) $display("FAIL ovf_drop_cyc: got %0d want %0d", drop_cyc[0], t5); else passed++;
    total++; if (drop_cnt[1] != 0) $display("FAIL ovf_drop_ch1: got %0d want 0", drop_cnt[1]); else passed++;
    total++; if (log_dat.size() != 0) $display("FAIL ovf_no_out: got %0d words want 0", log_dat.size()); else passed++;
    clr();
    drive(2'b01, mk(2'b01, 32'h50), '0);
    drive(2'b01, mk(2'b10, 32'h51), '0);
    t = cyc;
    step(8);
    total++; if (log_dat.size() != 2) $display("FAIL ovf_next_count: got %0d want 2", log_dat.size()); else passed++;
    got = (log_dat.size() > 0) ? log_dat[0] : '1;
    total++; if (got !== mk(2'b01, 32'h50)) $display("FAIL ovf_next_dat0: got %h want %h", got, mk(2'b01, 32'h50)); else passed++;
    got = (log_dat.size() > 1) ? log_dat[1] : '1;
    total++; if (got !== mk(2'b10, 32'h51)) $display("FAIL ovf_next_dat1: got %h want %h", got, mk(2'b10, 32'h51)); else passed++;
    total++; if (log_cyc.size() == 0 || log_cyc[0] != t + 2) $display("FAIL ovf_next_cyc: want %0d", t + 2); else passed++;
  endtask

  task automatic test_rollback();
    logic [W-1:0] got;
    clr();
    drive(2'b10, '0, mk(2'b01, 32'h60));
    drive(2'b10, '0, mk(2'b00, 32'h61));
    drive(2'b10, '0, mk(2'b01, 32'h70));
    drive(2'b10, '0, mk(2'b10, 32'h71));
    step(8);
    total++; if (drop_cnt[1] != 1) $display("FAIL rb_drop_cnt: got %0d want 1", drop_cnt[1]); else passed++;
    total++; if (drop_cnt[0] != 0) $display("FAIL rb_drop_ch0: got %0d want 0", drop_cnt[0]); else passed++;
    total++; if (log_dat.size() != 2) $display("FAIL rb_count: got %0d want 2", log_dat.size()); else passed++;
    got = (log_dat.size() > 0) ? log_dat[0] : '1;
    total++; if (got !== mk(2'b01, 32'h70)) $display("FAIL rb_dat0: got %h want %h", got, mk(2'b01, 32'h70)); else passed++;
    got = (log_dat.size() > 1) ? log_dat[1] : '1;
    total++; if (got !== mk(2'b10, 32'h71)) $display("FAIL rb_dat1: got %h want %h", got, mk(2'b10, 32'h71)); else passed++;
    total++; if (log_ch.size() == 0 || log_ch[0] !== 1'b1) $display("FAIL rb_ch: want 1"); else passed++;
  endtask

  task automatic test_orphan();
    clr();
    drive(2'b01, mk(2'b00, 32'h80), '0);
    drive(2'b01, mk(2'b10, 32'h81), '0);
    drive(2'b01, mk(2'b00, 32'h82), '0);
    step(8);
    total++; if (log_dat.size() != 0) $display("FAIL orphan_out: got %0d words want 0", log_dat.size()); else passed++;
    total++; if (drop_cnt[0] != 0) $display("FAIL orphan_drop: got %0d want 0", drop_cnt[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int t;
    clr();
    drive(2'b01, mk(2'b11, 32'h90), '0);
    t = cyc;
    drive(2'b01, mk(2'b11, 32'h91), '0);
    step(8);
    total++; if (log_dat.size() != 2) $display("FAIL b2b_count: got %0d want 2", log_dat.size()); else passed++;
    total++; if (log_cyc.size() < 1 || log_cyc[0] != t + 2) $display("FAIL b2b_cyc0: want %0d", t + 2); else passed++;
    total++; if (log_cyc.size() < 2 || log_cyc[1] != t + 4) $display("FAIL b2b_cyc1: want %0d", t + 4); else passed++;
    total++; if (log_dat.size() < 2 || log_dat[1] !== mk(2'b11, 32'h91)) $display("FAIL b2b_dat1: want %h", mk(2'b11, 32'h91)); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    clr();
    drive(2'b01, mk(2'b01, 32'ha0), '0);
    drive(2'b01, mk(2'b00, 32'ha1), '0);
    drive(2'b01, mk(2'b00, 32'ha2), '0);
    drive(2'b01, mk(2'b10, 32'ha3), '0);
    step(2);
    total++; if (data_out_valid !== 1'b1 || data_out !== mk(2'b01, 32'ha0)) $display("FAIL mid_first: got vld %b dat %h want 1/%h", data_out_valid, data_out, mk(2'b01, 32'ha0)); else passed++;
    rst = 1'b1;
    step(1);
    total++; if (data_out_valid !== 1'b0) $display("FAIL mid_vld: got %b want 0", data_out_valid); else passed++;
    total++; if (data_out !== '0) $display("FAIL mid_dat: got %h want 0", data_out); else passed++;
    rst = 1'b0;
    clr();
    step(10);
    total++; if (log_dat.size() != 0) $display("FAIL mid_no_more: got %0d words want 0", log_dat.size()); else passed++;
    drive(2'b01, mk(2'b11, 32'hb0), '0);
    step(6);
    total++; if (log_dat.size() != 1) $display("FAIL mid_new_count: got %0d want 1", log_dat.size()); else passed++;
    got = (log_dat.size() > 0) ? log_dat[0] : '1;
    total++; if (got !== mk(2'b11, 32'hb0)) $display("FAIL mid_new_dat: got %h want %h", got, mk(2'b11, 32'hb0)); else passed++;
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_same_cycle();
    test_overflow();
    test_rollback();
    test_orphan();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
